hilo_pipe: RTL and testbench

//  Receiving end of the EX-stage HI/LO write interface (whilo/hi/lo).
//  - Carries EX HI/LO writes through the EX/MEM and MEM/WB pipeline registers.
//  - Commits them to the architected HI and LO registers.
//  - Returns MEM-stage and WB-stage copies to EX as forwarding inputs (mem_*, wb_*),

---
 rtl/hilo_pipe_if.sv | 30 +++
 rtl/hilo_pipe.sv | 81 ++++++++
 tb/tb_hilo_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hilo_pipe_if.sv
// rtl/hilo_pipe_if.sv - HI/LO pipeline bundle between the EX stage and hilo_pipe
interface hilo_pipe_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        stall_i;
  logic              flush_i;
  logic              ex_whilo_i;
  logic [DATA_W-1:0] ex_hi_i;
  logic [DATA_W-1:0] ex_lo_i;
  logic              mem_whilo_o;
  logic [DATA_W-1:0] mem_hi_o;
  logic [DATA_W-1:0] mem_lo_o;
  logic              wb_whilo_o;
  logic [DATA_W-1:0] wb_hi_o;
  logic [DATA_W-1:0] wb_lo_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output stall_i, flush_i, ex_whilo_i, ex_hi_i, ex_lo_i,
    input  mem_whilo_o, mem_hi_o, mem_lo_o,
    input  wb_whilo_o, wb_hi_o, wb_lo_o, hi_o, lo_o
  );

  modport slave (
    input  stall_i, flush_i, ex_whilo_i, ex_hi_i, ex_lo_i,
    output mem_whilo_o, mem_hi_o, mem_lo_o,
    output wb_whilo_o, wb_hi_o, wb_lo_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_pipe.sv
// rtl/hilo_pipe.sv - EX/MEM and MEM/WB HI/LO pipeline with architected HI/LO commit
// Optional: HILO_WB_BYPASS_EN makes hi_o/lo_o write-through the committing WB value.
module hilo_pipe #(
  parameter int DATA_W = 32
) (
  input logic        clk,
  input logic        rst,
  hilo_pipe_if.slave bus
);
  logic              mem_we;
  logic [DATA_W-1:0] mem_hi;
  logic [DATA_W-1:0] mem_lo;
  logic              wb_we;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;

  logic mem_bubble;
  logic mem_load;
  logic wb_bubble;

  // EX stalled while MEM advances means nothing valid leaves EX this cycle.
  assign mem_bubble = bus.flush_i || (bus.stall_i == 2'b01);
  assign mem_load   = !bus.stall_i[0];
  assign wb_bubble  = bus.flush_i || bus.stall_i[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_we <= 1'b0;
      mem_hi <= '0;
      mem_lo <= '0;
      wb_we  <= 1'b0;
      wb_hi  <= '0;
      wb_lo  <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      if (mem_bubble) begin
        mem_we <= 1'b0;
        mem_hi <= '0;
        mem_lo <= '0;
      end else if (mem_load) begin
        mem_we <= bus.ex_whilo_i;
        mem_hi <= bus.ex_hi_i;
        mem_lo <= bus.ex_lo_i;
      end

      if (wb_bubble) begin
        wb_we <= 1'b0;
        wb_hi <= '0;
        wb_lo <= '0;
      end else begin
        wb_we <= mem_we;
        wb_hi <= mem_hi;
        wb_lo <= mem_lo;
      end

      // The write already in WB commits even under flush.
      if (wb_we) begin
        hi_r <= wb_hi;
        lo_r <= wb_lo;
      end
    end
  end

  assign bus.mem_whilo_o = mem_we;
  assign bus.mem_hi_o    = mem_hi;
  assign bus.mem_lo_o    = mem_lo;
  assign bus.wb_whilo_o  = wb_we;
  assign bus.wb_hi_o     = wb_hi;
  assign bus.wb_lo_o     = wb_lo;

`ifdef HILO_WB_BYPASS_EN
  assign bus.hi_o = wb_we ? wb_hi : hi_r;
  assign bus.lo_o = wb_we ? wb_lo : lo_r;
`else
  assign bus.hi_o = hi_r;
  assign bus.lo_o = lo_r;
`endif
endmodule

// File: tb/tb_hilo_pipe.sv
// tb/tb_hilo_pipe.sv - directed and randomized checks of hilo_pipe against a stage-queue model
module tb_hilo_pipe;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hilo_pipe_if #(.DATA_W(DW)) bus ();
  hilo_pipe #(.DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic          we;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } xfer_t;

  // slot[0] = write sitting in MEM, slot[1] = write sitting in WB
  xfer_t         slot [2];
  logic [DW-1:0] arch_hi, arch_lo;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic [1:0] st, input logic fl, input xfer_t ex, input logic r);
    xfer_t to_mem, to_wb;
    if (!r) begin
      slot[0] = '0;
      slot[1] = '0;
      arch_hi = '0;
      arch_lo = '0;
    end else begin
      if (slot[1].we) begin
        arch_hi = slot[1].hi;
        arch_lo = slot[1].lo;
      end
      to_wb = (fl || st[1]) ? xfer_t'('0) : slot[0];
      if (fl || st == 2'b01) to_mem = '0;
      else if (!st[0])       to_mem = ex;
      else                   to_mem = slot[0];
      slot[0] = to_mem;
      slot[1] = to_wb;
    end
  endtask

  task automatic compare_all();
    logic [DW-1:0] eh, el;
    eh = arch_hi;
    el = arch_lo;
`ifdef HILO_WB_BYPASS_EN
    if (slot[1].we) begin
      eh = slot[1].hi;
      el = slot[1].lo;
    end
`endif
    check("mem_whilo", 64'(bus.mem_whilo_o), 64'(slot[0].we));
    check("mem_hilo", {bus.mem_hi_o, bus.mem_lo_o}, {slot[0].hi, slot[0].lo});
    check("wb_whilo", 64'(bus.wb_whilo_o), 64'(slot[1].we));
    check("wb_hilo", {bus.wb_hi_o, bus.wb_lo_o}, {slot[1].hi, slot[1].lo});
    check("arch_hilo", {bus.hi_o, bus.lo_o}, {eh, el});
  endtask

  task automatic cycle(input logic [1:0] st, input logic fl, input logic we,
                       input logic [DW-1:0] hi, input logic [DW-1:0] lo, input logic r);
    xfer_t ex;
    bus.stall_i    = st;
    bus.flush_i    = fl;
    bus.ex_whilo_i = we;
    bus.ex_hi_i    = hi;
    bus.ex_lo_i    = lo;
    rst            = r;
    ex = '{we: we, hi: hi, lo: lo};
    @(posedge clk);
    model_step(st, fl, ex, r);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  logic [DW-1:0] saved_hi, saved_lo;

  initial begin
    slot[0] = '0;
    slot[1] = '0;
    arch_hi = '0;
    arch_lo = '0;

    // reset held with an active write on the inputs
    cycle(2'b00, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    cycle(2'b00, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("rst_mem_we", 64'(bus.mem_whilo_o), 64'd0);
    check("rst_wb_we", 64'(bus.wb_whilo_o), 64'd0);
    check("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    check("rst_mem_data", {bus.mem_hi_o, bus.mem_lo_o}, 64'd0);

    // single write latency
    cycle(2'b00, 1'b0, 1'b1, 32'h0000_1234, 32'h0000_5678, 1'b1);
    check("single_mem", {bus.mem_hi_o, bus.mem_lo_o}, {32'h1234, 32'h5678});
    check("single_arch_n1", {bus.hi_o, bus.lo_o}, 64'd0);
    idle(1);
    check("single_wb", {bus.wb_hi_o, bus.wb_lo_o}, {32'h1234, 32'h5678});
`ifdef HILO_WB_BYPASS_EN
    check("single_arch_n2", {bus.hi_o, bus.lo_o}, {32'h1234, 32'h5678});
`else
    check("single_arch_n2", {bus.hi_o, bus.lo_o}, 64'd0);
`endif
    idle(1);
    check("single_arch_n3", {bus.hi_o, bus.lo_o}, {32'h1234, 32'h5678});

    // back-to-back A,B,C
    cycle(2'b00, 1'b0, 1'b1, 32'd1, 32'h10, 1'b1);
    cycle(2'b00, 1'b0, 1'b1, 32'd2, 32'h20, 1'b1);
    check("b2b_wb_a", 64'(bus.wb_hi_o), 64'd1);
    cycle(2'b00, 1'b0, 1'b1, 32'd3, 32'h30, 1'b1);
    check("b2b_wb_b", 64'(bus.wb_hi_o), 64'd2);
    idle(1);
    check("b2b_wb_c", 64'(bus.wb_hi_o), 64'd3);
    idle(1);
    check("b2b_final", 64'(bus.hi_o), 64'd3);

    // EX stall, then MEM+EX stall hold
    cycle(2'b01, 1'b0, 1'b1, 32'h77, 32'h88, 1'b1);
    check("stall01_bubble", 64'(bus.mem_whilo_o), 64'd0);
    cycle(2'b00, 1'b0, 1'b1, 32'h77, 32'h88, 1'b1);
    check("stall_release", {31'd0, bus.mem_whilo_o, bus.mem_hi_o}, {32'd1, 32'h77});
    cycle(2'b11, 1'b0, 1'b1, 32'h99, 32'hAA, 1'b1);
    check("stall11_hold", {31'd0, bus.mem_whilo_o, bus.mem_hi_o}, {32'd1, 32'h77});
    idle(3);

    // flush with W1 in MEM and W2 in EX
    saved_hi = arch_hi;
    saved_lo = arch_lo;
    cycle(2'b00, 1'b0, 1'b1, 32'hAAAA, 32'hBBBB, 1'b1);
    cycle(2'b00, 1'b1, 1'b1, 32'hCCCC, 32'hDDDD, 1'b1);
    check("flush_mem_we", 64'(bus.mem_whilo_o), 64'd0);
    check("flush_wb_we", 64'(bus.wb_whilo_o), 64'd0);
    idle(3);
    check("flush_no_commit", {bus.hi_o, bus.lo_o}, {saved_hi, saved_lo});

    // reset with writes in MEM and WB
    cycle(2'b00, 1'b0, 1'b1, 32'h1111, 32'h2222, 1'b1);
    cycle(2'b00, 1'b0, 1'b1, 32'h3333, 32'h4444, 1'b1);
    cycle(2'b00, 1'b0, 1'b0, '0, '0, 1'b0);
    check("midrst_we", {63'd0, bus.mem_whilo_o | bus.wb_whilo_o}, 64'd0);
    check("midrst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    idle(3);
    check("midrst_no_commit", {bus.hi_o, bus.lo_o}, 64'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] st;
      logic fl, we, r;
      st = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(0, 3)) : 2'b00;
      fl = ($urandom_range(0, 19) == 0);
      we = ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 99) != 0);
      cycle(st, fl, we, $urandom, $urandom, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
